atomicity_mon_multi: RTL and testbench
======================================

Name: atomicity_mon_multi

Overview:
- Parametrised successor to the single-region atomicity monitor.
- Watches the CPU program counter against NREG independent protected code regions (e.g. SW-Att ROM, secure-update ROM).
- Each region must be entered only at its first address, exited only from its last address, and must not be interrupted.
- Any violation drives a sticky kill (system reset request) and records the cause until the CPU fetches the reset vector.

Parameters:
- NREG, 2, number of protected regions (1..8).
- REG_BASE, {16'hE000,16'hA000}, packed NREG x 16-bit region base addresses; region r is slice r.
- REG_SIZE, {16'h1000,16'h1000}, packed NREG x 16-bit region sizes in bytes (even, >= 4).
- RESET_HANDLER, 16'hFFFE, PC value that releases kill.
- RIDX_W, 3, width of the violating-region index (>= clog2(NREG), minimum 1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- pc  in  16  current program counter
- pc_en  in  1  pc valid this cycle (instruction fetch strobe)
- irq  in  1  interrupt being taken by the CPU
- kill  out  1  registered violation/reset request
- viol_code  out  2  cause of the latched violation: 00 reset, 01 bad entry, 10 bad exit/jump, 11 irq in region
- viol_region  out  RIDX_W  index of the region that caused the violation

Behaviour:
- Interface: one clock `clk`. Reset `reset` is synchronous and active-high.
- Per region r: FIRST = BASE; LAST = BASE + SIZE - 2 (16-bit, no wrap; regions must not overlap or wrap past 16'hFFFF).
- pc classification per region: is_first, is_last, is_mid (FIRST < pc < LAST), is_out (pc < FIRST or pc > LAST). Exactly one is true.
- Per-region FSM states: NOTR, FST, MID, LST, KILL. Transitions are evaluated only when pc_en = 1; when pc_en = 0, state holds.
- NOTR transitions:
  - is_out -> NOTR
  - is_first -> FST
  - is_mid or is_last -> KILL, code 01
- FST transitions:
  - is_first -> FST
  - is_mid -> MID
  - is_out or is_last -> KILL, code 10
- MID transitions:
  - is_mid -> MID
  - is_last -> LST
  - is_out or is_first -> KILL, code 10
- LST transitions:
  - is_last -> LST
  - is_out -> NOTR
  - is_first or is_mid -> KILL, code 10
- KILL transition: pc == RESET_HANDLER with pc_en -> NOTR for ALL regions in the same cycle; otherwise hold.
- irq rule: see Optional Feature.
- Global kill: once any region enters KILL, every region is forced to KILL on the next edge. kill = 1 whenever the regions are in KILL (registered, 1-cycle latency from the offending pc sample).
- Cause latch: viol_code/viol_region load only on the NOT-killed -> killed transition; they hold while killed.
- Simultaneous violations in the same cycle: the lowest region index wins.
- Exit from kill: the RESET_HANDLER fetch clears kill on the next edge. viol_code/viol_region keep their values, for post-reset software readout, until the next violation or reset.
- Reset (dominates all inputs, including mid-region and RESET_HANDLER on the same cycle):
  - All regions go to KILL; kill = 1.
  - viol_code = 00; viol_region = 0.
  - The monitor therefore requires a RESET_HANDLER fetch before any region can be used.
- A pc value equal to RESET_HANDLER while not killed is treated as ordinary is_out.

Optional Feature:
- Macro: ATOM_IRQ_KILL_EN.
- Defined: in FST, MID or LST, irq = 1 (sampled regardless of pc_en) -> KILL, code 11. irq takes priority over a pc-based legal transition in the same cycle. In NOTR and KILL, irq is ignored.
- Undefined: the irq input is ignored entirely and code 11 is never produced.

Decomposition:
- Shared package atom_pkg holds:
  - the state encoding (NOTR=3'b000, FST=3'b001, LST=3'b010, MID=3'b011, KILL=3'b100);
  - the viol_code constants;
  - the default RESET_HANDLER.
- Sub-module atom_region_fsm, instantiated NREG times via generate:
  - inputs: region FIRST/LAST, pc, pc_en, irq, global_kill, clear;
  - outputs: its state and its violation request + code.
- The top module holds the kill OR, the priority encoder and the cause registers.

Test Plan:
- Reset, then pc_en with pc = 16'hFFFE -> kill = 1 during reset, kill = 0 one cycle after the fetch; viol_code = 00.
- Region 0 legal run (NREG = 2): pc sequence E000, E002, E7F0, EFFE, 4000 -> kill stays 0 throughout.
- Jump into middle: from 4000, pc = E010 -> kill = 1 next cycle, viol_code = 01, viol_region = 0. pc = FFFE -> kill = 0.
- Early exit from region 1: A000, A004, 5000 -> kill = 1, viol_code = 10, viol_region = 1. Region 0 state also shows KILL.
- pc_en gating: inside region 0 at E004, drive pc = 4000 with pc_en = 0 for 3 cycles, then pc = EFFE with pc_en = 1 -> no kill. Then 4000 with pc_en = 1 -> kill stays 0.
- ATOM_IRQ_KILL_EN defined: irq = 1 while at E008 -> kill = 1, viol_code = 11. Same stimulus without the macro -> kill stays 0.

Source files
------------

// File: rtl/atom_pkg.sv
// Shared types and constants for the multi-region atomicity monitor.
// The optional irq-kill rule is enabled with ATOM_IRQ_KILL_EN (see atom_region_fsm).
package atom_pkg;

  typedef enum logic [2:0] {
    ST_NOTR = 3'b000,
    ST_FST  = 3'b001,
    ST_LST  = 3'b010,
    ST_MID  = 3'b011,
    ST_KILL = 3'b100
  } atom_state_e;

  localparam logic [1:0] VC_RESET = 2'b00;
  localparam logic [1:0] VC_ENTRY = 2'b01;
  localparam logic [1:0] VC_EXIT  = 2'b10;
  localparam logic [1:0] VC_IRQ   = 2'b11;

  localparam logic [15:0] ATOM_RESET_HANDLER = 16'hFFFE;

  // Violation request raised by one region in the current cycle.
  typedef struct packed {
    logic       req;
    logic [1:0] code;
  } atom_viol_t;

endpackage

// File: rtl/atom_region_fsm.sv
// Per-region atomicity FSM: tracks NOTR/FST/MID/LST and raises a violation
// request when the pc stream breaks the enter-at-first / leave-from-last rule.
// Macro ATOM_IRQ_KILL_EN: when defined, an irq taken inside the region kills (code 11).
module atom_region_fsm
  import atom_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] first,
  input  logic [15:0] last,
  input  logic [15:0] pc,
  input  logic        pc_en,
  input  logic        irq,
  input  logic        global_kill,
  input  logic        clear,
  output atom_state_e state,
  output atom_viol_t  viol
);

  atom_state_e state_q, state_d;
  logic is_first, is_last, is_mid;

  // Classify pc against this region; anything not first/mid/last is outside.
  always_comb begin
    is_first = (pc == first);
    is_last  = (pc == last);
    is_mid   = (pc > first) && (pc < last);
  end

  // Own violation detection, then global overrides: reset > clear > global kill.
  always_comb begin
    viol.req  = 1'b0;
    viol.code = VC_RESET;
    state_d   = state_q;
    if (pc_en) begin
      unique case (state_q)
        ST_NOTR: begin
          if (is_first)              state_d = ST_FST;
          else if (is_mid || is_last) begin viol.req = 1'b1; viol.code = VC_ENTRY; end
        end
        ST_FST: begin
          if (is_mid)                state_d = ST_MID;
          else if (!is_first)        begin viol.req = 1'b1; viol.code = VC_EXIT; end
        end
        ST_MID: begin
          if (is_last)               state_d = ST_LST;
          else if (!is_mid)          begin viol.req = 1'b1; viol.code = VC_EXIT; end
        end
        ST_LST: begin
          if (!is_first && !is_mid && !is_last) state_d = ST_NOTR;
          else if (!is_last)         begin viol.req = 1'b1; viol.code = VC_EXIT; end
        end
        default: ;
      endcase
    end
`ifdef ATOM_IRQ_KILL_EN
    // An interrupt inside the region beats any pc-based outcome this cycle.
    if (irq && (state_q == ST_FST || state_q == ST_MID || state_q == ST_LST)) begin
      viol.req  = 1'b1;
      viol.code = VC_IRQ;
    end
`endif
    if (viol.req)         state_d = ST_KILL;
    if (global_kill)      state_d = ST_KILL;
    if (clear)            state_d = ST_NOTR;
    if (reset)            state_d = ST_KILL;
  end

`ifndef ATOM_IRQ_KILL_EN
  logic unused_irq;
  assign unused_irq = irq;
`endif

  // State register.
  always_ff @(posedge clk) state_q <= state_d;

  assign state = state_q;

endmodule

// File: rtl/atomicity_mon_multi.sv
// Multi-region atomicity monitor: NREG region FSMs, a sticky global kill,
// lowest-index cause selection and the post-reset cause readout registers.
// Macro ATOM_IRQ_KILL_EN (handled in atom_region_fsm) enables irq-in-region kills.
module atomicity_mon_multi
  import atom_pkg::*;
#(
  parameter int               NREG          = 2,
  parameter logic [NREG*16-1:0] REG_BASE    = {16'hE000, 16'hA000},
  parameter logic [NREG*16-1:0] REG_SIZE    = {16'h1000, 16'h1000},
  parameter logic [15:0]      RESET_HANDLER = ATOM_RESET_HANDLER,
  parameter int               RIDX_W        = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       pc,
  input  logic              pc_en,
  input  logic              irq,
  output logic              kill,
  output logic [1:0]        viol_code,
  output logic [RIDX_W-1:0] viol_region
);

  logic [NREG-1:0][15:0] first, last;
  atom_state_e           state [NREG];
  atom_viol_t            viol  [NREG];
  logic [NREG-1:0]       in_kill;

  logic              kill_q, kill_d;
  logic [1:0]        code_q, code_d;
  logic [RIDX_W-1:0] ridx_q, ridx_d;
  logic              clear, any_req;
  logic [1:0]        sel_code;
  logic [RIDX_W-1:0] sel_ridx;

  // Only a reset-vector fetch while killed releases the regions.
  assign clear = kill_q && pc_en && (pc == RESET_HANDLER);

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    assign first[r] = REG_BASE[r*16 +: 16];
    assign last[r]  = REG_BASE[r*16 +: 16] + REG_SIZE[r*16 +: 16] - 16'd2;

    atom_region_fsm u_fsm (
      .clk         (clk),
      .reset       (reset),
      .first       (first[r]),
      .last        (last[r]),
      .pc          (pc),
      .pc_en       (pc_en),
      .irq         (irq),
      .global_kill (kill_q),
      .clear       (clear),
      .state       (state[r]),
      .viol        (viol[r])
    );

    assign in_kill[r] = (state[r] == ST_KILL);
  end

  // Region states are exported for debug visibility only.
  logic unused_in_kill;
  assign unused_in_kill = ^in_kill;

  // Priority encode: walk downwards so the lowest requesting index wins.
  always_comb begin
    any_req  = 1'b0;
    sel_code = VC_RESET;
    sel_ridx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (viol[i].req) begin
        any_req  = 1'b1;
        sel_code = viol[i].code;
        sel_ridx = RIDX_W'(i);
      end
    end
  end

  // Sticky kill and cause capture on the not-killed -> killed edge only.
  always_comb begin
    kill_d = kill_q;
    code_d = code_q;
    ridx_d = ridx_q;
    if (clear) begin
      kill_d = 1'b0;
    end else if (!kill_q && any_req) begin
      kill_d = 1'b1;
      code_d = sel_code;
      ridx_d = sel_ridx;
    end
    if (reset) begin
      kill_d = 1'b1;
      code_d = VC_RESET;
      ridx_d = '0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    kill_q <= kill_d;
    code_q <= code_d;
    ridx_q <= ridx_d;
  end

  assign kill        = kill_q;
  assign viol_code   = code_q;
  assign viol_region = ridx_q;

endmodule

// File: tb/tb_atomicity_mon_multi.sv
// Randomized self-checking bench for atomicity_mon_multi against a
// position-class reference model. Honours ATOM_IRQ_KILL_EN if defined.
module tb_atomicity_mon_multi;

  localparam int NREG   = 2;
  localparam int RIDX_W = 3;
  localparam logic [NREG*16-1:0] BASE = {16'hA000, 16'hE000};
  localparam logic [NREG*16-1:0] SIZE = {16'h1000, 16'h1000};
  localparam logic [15:0] RH = 16'hFFFE;
`ifdef ATOM_IRQ_KILL_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, pc_en = 1'b0, irq = 1'b0;
  logic [15:0] pc = 16'h0;
  logic kill;
  logic [1:0] viol_code;
  logic [RIDX_W-1:0] viol_region;

  atomicity_mon_multi #(
    .NREG(NREG), .REG_BASE(BASE), .REG_SIZE(SIZE),
    .RESET_HANDLER(RH), .RIDX_W(RIDX_W)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_en(pc_en), .irq(irq),
    .kill(kill), .viol_code(viol_code), .viol_region(viol_region)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Model: position class per region, 0 out / 1 first / 2 mid / 3 last.
  // A legal step keeps the class or advances it by one, cyclically.
  bit m_killed = 1'b1;
  int m_code = 0, m_reg = 0;
  int m_prev [NREG];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int lo(input int r);
    lo = int'(BASE[r*16 +: 16]);
  endfunction

  function automatic int hi(input int r);
    hi = int'(BASE[r*16 +: 16]) + int'(SIZE[r*16 +: 16]) - 2;
  endfunction

  function automatic int cls(input int r, input int p);
    if (p == lo(r))                  cls = 1;
    else if (p == hi(r))             cls = 3;
    else if (p > lo(r) && p < hi(r)) cls = 2;
    else                             cls = 0;
  endfunction

  function automatic logic [15:0] pc_of(input int r, input int c);
    int span;
    span = (hi(r) - lo(r)) / 2;
    case (c)
      1:       pc_of = 16'(lo(r));
      2:       pc_of = 16'(lo(r) + 2 * $urandom_range(1, span - 1));
      3:       pc_of = 16'(hi(r));
      default: pc_of = 16'h4000 + 16'(2 * $urandom_range(0, 255));
    endcase
  endfunction

  task automatic model_edge(input bit rst, input int p, input bit en, input bit ir);
    int cur, vr, vc;
    if (rst) begin
      m_killed = 1'b1; m_code = 0; m_reg = 0;
      foreach (m_prev[r]) m_prev[r] = 0;
    end else if (m_killed) begin
      if (en && p == int'(RH)) begin
        m_killed = 1'b0;
        foreach (m_prev[r]) m_prev[r] = 0;
      end
    end else begin
      vr = -1; vc = 0;
      for (int r = 0; r < NREG; r++) begin
        cur = cls(r, p);
        if (vr < 0) begin
          if (IRQ_EN && ir && m_prev[r] != 0) begin
            vr = r; vc = 3;
          end else if (en && cur != m_prev[r] && cur != (m_prev[r] + 1) % 4) begin
            vr = r; vc = (m_prev[r] == 0) ? 1 : 2;
          end
        end
      end
      if (vr >= 0) begin
        m_killed = 1'b1; m_code = vc; m_reg = vr;
      end else if (en) begin
        for (int r = 0; r < NREG; r++) m_prev[r] = cls(r, p);
      end
    end
  endtask

  task automatic step(input bit rst, input logic [15:0] p, input bit en, input bit ir);
    reset = rst; pc = p; pc_en = en; irq = ir;
    @(posedge clk);
    model_edge(rst, int'(p), en, ir);
    #1;
    chk("kill", int'(kill), int'(m_killed));
    chk("viol_code", int'(viol_code), m_code);
    chk("viol_region", int'(viol_region), m_reg);
  endtask

  initial begin
    int r, c, k;
    logic [15:0] p;
    foreach (m_prev[i]) m_prev[i] = 0;

    // Reset dominates even a reset-vector fetch, then release.
    step(1, 16'hE004, 1, 0);
    step(1, RH, 1, 0);
    step(0, RH, 1, 0);
    chk("released", int'(kill), 0);
    // Legal pass through region 0.
    step(0, 16'hE000, 1, 0); step(0, 16'hE002, 1, 0); step(0, 16'hE7F0, 1, 0);
    step(0, 16'hEFFE, 1, 0); step(0, 16'h4000, 1, 0);
    // Jump into the middle of region 0.
    step(0, 16'hE010, 1, 0);
    chk("entry_code", int'(viol_code), 1);
    step(0, RH, 1, 0);
    // Early exit from region 1.
    step(0, 16'hA000, 1, 0); step(0, 16'hA004, 1, 0); step(0, 16'h5000, 1, 0);
    chk("exit_region", int'(viol_region), 1);
    step(0, 16'h5002, 1, 0);
    chk("r0_forced", int'(dut.g_reg[0].u_fsm.state), 4);
    step(0, RH, 1, 0);
    chk("code_kept", int'(viol_code), 2);
    // pc_en gating inside region 0.
    step(0, 16'hE000, 1, 0); step(0, 16'hE004, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 16'h4000, 0, 0);
    step(0, 16'hEFFE, 1, 0); step(0, 16'h4000, 1, 0);
    // irq inside region 0.
    step(0, 16'hE000, 1, 0); step(0, 16'hE008, 1, 0); step(0, 16'hE008, 1, 1);
    step(0, 16'hE00A, 1, 0);
    step(0, RH, 1, 0);
    step(0, 16'h4000, 1, 0);

    // Random walk, biased towards legal progressions.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, NREG - 1);
      k = $urandom_range(0, 99);
      if (k < 8)       p = RH;
      else if (k < 65) begin
        c = (m_prev[r] + $urandom_range(0, 1)) % 4;
        p = pc_of(r, c);
      end else         p = pc_of(r, $urandom_range(0, 3));
      step(($urandom_range(0, 299) == 0), p, ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 39) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
